// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU run/step controller:
//   run_state_t              - HALT / RUN / STEP controller states
//   DEBOUNCE_CYCLES_DEFAULT  - button debounce window (10 ms at 27 MHz)
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

endpackage

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronizes an asynchronous active-low push button into clk_in, debounces
// it and emits a single-cycle pulse when a press (released -> pressed) is
// accepted. Releases produce no pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a pin change is accepted
// Ports:
//   clk_in  in   system clock
//   rst_n   in   asynchronous active-low reset
//   btn_n   in   raw button pin, active-low, asynchronous
//   press   out  one-cycle registered pulse on an accepted press
// ---------------------------------------------------------------------------
module button_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;   // accepted (debounced) pin level
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  logic differ;
  logic accept;

  assign differ = (sync2_reg != stable_reg);
  // The counter only climbs while the pin disagrees with the accepted level,
  // so reaching the last count means it has been stable for the full window.
  assign accept = differ && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (accept) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      // Only the 1 -> 0 (press) transition is an event.
      press_reg <= accept & ~sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run/step controller for the 6502 core. Converts rising edges of the divided
// clock into one-cycle cpu_en pulses, gated by a HALT/RUN/STEP state machine
// driven by two debounced buttons and the core's halt request.
//
// Build option: define CPU_RUN_CTRL_CYCLE_COUNT_EN to build the cpu_en pulse
// counter; without it cycle_count is tied to zero.
//
// Parameters:
//   DEBOUNCE_CYCLES  button debounce window in clk_in cycles
//   CNT_W            width of cycle_count
// Ports:
//   clk_in       in   system clock
//   rst_n        in   asynchronous active-low reset
//   div_clk      in   divided clock, synchronous to clk_in
//   btn_run_n    in   run/halt toggle button, active-low, asynchronous
//   btn_step_n   in   single-step button, active-low, asynchronous
//   halt_req     in   level halt request from the core
//   cpu_en       out  one-cycle CPU clock enable
//   running      out  high while in RUN
//   cycle_count  out  number of cpu_en pulses issued (wraps)
// ---------------------------------------------------------------------------
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_clk,
  input  logic             btn_run_n,
  input  logic             btn_step_n,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  // ---- Button paths: index 0 = run, index 1 = step ----
  logic [1:0] btn_n_w;
  logic [1:0] press_w;

  assign btn_n_w = {btn_step_n, btn_run_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .btn_n (btn_n_w[gi]),
      .press (press_w[gi])
    );
  end

  logic run_press;
  logic step_press;

  assign run_press  = press_w[0];
  assign step_press = press_w[1];

  // ---- div_clk rising-edge detect ----
  logic div_clk_q_reg;
  logic div_edge;

  assign div_edge = div_clk & ~div_clk_q_reg;

  // ---- State machine ----
  run_state_t state_reg;
  run_state_t state_next;
  logic       cpu_en_reg;
  logic       cpu_en_next;
  logic       running_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HALT;
      div_clk_q_reg <= 1'b0;
      cpu_en_reg    <= 1'b0;
      running_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_clk_q_reg <= div_clk;
      cpu_en_reg    <= cpu_en_next;
      // Registered from the next state so running tracks state_reg exactly.
      running_reg   <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cpu_en_next = 1'b0;
    case (state_reg)
      HALT: begin
        // Run wins over step only when the core is not requesting a halt.
        if (run_press && !halt_req) begin
          state_next = RUN;
        end else if (step_press) begin
          state_next = STEP;
        end
      end
      RUN: begin
        // halt_req suppresses a coincident edge: no pulse in that cycle.
        if (halt_req || run_press) begin
          state_next = HALT;
        end else if (div_edge) begin
          cpu_en_next = 1'b1;
        end
      end
      STEP: begin
        if (div_edge) begin
          cpu_en_next = 1'b1;
          state_next  = HALT;
        end
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  assign cpu_en  = cpu_en_reg;
  assign running = running_reg;

  // ---- Pulse counter ----
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (cpu_en_reg) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign cycle_count = count_reg;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl (DEBOUNCE_CYCLES=4, CNT_W=3, div_clk
// period 6 cycles). div_clk is held low while buttons are operated, so the
// reference model only needs to track the controller mode and how many
// enable pulses each burst of div_clk periods should produce.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 3;

  logic          clk_in     = 1'b0;
  logic          rst_n      = 1'b0;
  logic          div_clk    = 1'b0;
  logic          btn_run_n  = 1'b1;
  logic          btn_step_n = 1'b1;
  logic          halt_req   = 1'b0;
  logic          cpu_en;
  logic          running;
  logic [CW-1:0] cycle_count;

  int checks      = 0;
  int errors      = 0;
  int seen_pulses = 0;

  // Reference model state
  bit m_running      = 1'b0;
  bit m_step_pending = 1'b0;
  int m_total        = 0;   // pulses expected since time zero
  int m_since_reset  = 0;   // pulses expected since last reset

  bit d1 = 1'b0;
  bit d2 = 1'b0;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .div_clk    (div_clk),
    .btn_run_n  (btn_run_n),
    .btn_step_n (btn_step_n),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .running    (running),
    .cycle_count(cycle_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every cpu_en must sit one cycle after a cycle in which div_clk rose.
  always @(negedge clk_in) begin
    if (rst_n && cpu_en) begin
      seen_pulses++;
      check_val("en_after_rise", {31'd0, d1 & ~d2}, 32'd1);
    end
    d2 = d1;
    d1 = div_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_cnt();
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    return 32'(m_since_reset % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic set_pin(input bit is_step, input logic v);
    if (is_step) btn_step_n = v;
    else         btn_run_n  = v;
  endtask

  task automatic press_btn(input bit is_step);
    set_pin(is_step, 1'b0);
    tick(10);
    set_pin(is_step, 1'b1);
    tick(10);
    if (m_step_pending) begin
      // presses ignored while a step waits for its edge
    end else if (is_step) begin
      if (!m_running) m_step_pending = 1'b1;
    end else if (m_running) begin
      m_running = 1'b0;
    end else if (!halt_req) begin
      m_running = 1'b1;
    end
  endtask

  task automatic bounce(input bit is_step);
    for (int i = 0; i < 10; i++) begin
      set_pin(is_step, (i % 2 == 0) ? 1'b0 : 1'b1);
      tick(2);
    end
    set_pin(is_step, 1'b1);
    tick(10);
  endtask

  task automatic periods(input int n);
    repeat (n) begin
      div_clk = 1'b1;
      tick(3);
      div_clk = 1'b0;
      tick(3);
    end
    tick(2);
    if (m_running) begin
      m_total       += n;
      m_since_reset += n;
    end else if (m_step_pending && n > 0) begin
      m_total       += 1;
      m_since_reset += 1;
      m_step_pending = 1'b0;
    end
  endtask

  task automatic set_halt(input bit v);
    halt_req = v;
    tick(3);
    if (v) m_running = 1'b0;
  endtask

  task automatic verify(input string tag);
    @(negedge clk_in);
    #1;
    check_val({tag, "_running"}, {31'd0, running}, {31'd0, m_running});
    check_val({tag, "_pulses"}, seen_pulses, m_total);
    check_val({tag, "_count"}, {29'd0, cycle_count}, exp_cnt());
    $display("op %-12s running=%0b count=%0d pulses=%0d", tag, running, cycle_count, seen_pulses);
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    m_running      = 1'b0;
    m_step_pending = 1'b0;
    m_since_reset  = 0;
    #2;
    check_val("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check_val("rst_running", {31'd0, running}, 32'd0);
    check_val("rst_count", {29'd0, cycle_count}, 32'd0);
    tick(2);
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int op;
    tick(3);
    verify("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(2);

    periods(10);         verify("idle");
    press_btn(1'b0);     verify("run_press");
    periods(5);          verify("run_5");
    press_btn(1'b0);     verify("run_toggle");

    reset_dut();         verify("reset_mid");
    press_btn(1'b1);     periods(1);
    press_btn(1'b1);     periods(1);
    verify("step_x2");

    bounce(1'b1);        periods(2); verify("bounce_step");
    bounce(1'b0);        periods(2); verify("bounce_run");

    // halt_req arriving together with a div_clk rise while running
    press_btn(1'b0);     verify("run_again");
    div_clk  = 1'b1;
    halt_req = 1'b1;
    @(negedge clk_in); #1;
    check_val("halt_cycle_running", {31'd0, running}, 32'd1);
    @(negedge clk_in); #1;
    check_val("halt_next_running", {31'd0, running}, 32'd0);
    check_val("halt_next_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(posedge clk_in); #1;
    tick(1);
    div_clk = 1'b0;
    tick(3);
    m_running = 1'b0;
    verify("halt_on_rise");
    press_btn(1'b0);     verify("run_while_hreq");
    press_btn(1'b1);     periods(1); verify("step_while_hreq");
    set_halt(1'b0);

    // pending step discarded by reset
    press_btn(1'b1);
    reset_dut();
    periods(2);          verify("step_reset");

    // counter wrap: 9 pulses on a 3-bit counter
    press_btn(1'b0);     periods(9);
    press_btn(1'b0);     verify("wrap_9");

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: press_btn(1'b0);
        1: press_btn(1'b1);
        2: bounce(1'($urandom_range(0, 1)));
        4: set_halt(1'($urandom_range(0, 1)));
        5: if ($urandom_range(0, 3) == 0) reset_dut();
           else periods($urandom_range(1, 4));
        default: periods($urandom_range(1, 4));
      endcase
      verify($sformatf("rand%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller downstream of the clock divider. Turns the divided clock `div_clk` into single-`clk_in`-cycle `cpu_en` pulses for the 6502 core, gated by a HALT/RUN/STEP state machine. The state machine is driven by two debounced, active-low board buttons and a CPU halt request. Everything runs in the `clk_in` domain; the CPU core uses `cpu_en` as its clock enable.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: stable-input cycles required to accept a button change (10 ms at 27 MHz).
- `CNT_W`, default 16: width of `cycle_count`.
- `clk_in`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `div_clk`  in  1  divided clock from the divider, synchronous to `clk_in`.
- `btn_run_n`  in  1  run/halt toggle button, active-low, asynchronous.
- `btn_step_n`  in  1  single-step button, active-low, asynchronous.
- `halt_req`  in  1  level halt request from the CPU core, synchronous.
- `cpu_en`  out  1  one-`clk_in`-cycle CPU clock-enable pulse.
- `running`  out  1  high while in RUN.
- `cycle_count`  out  CNT_W  number of `cpu_en` pulses issued.

## Operation
- **Reset values:** `cpu_en`=0, `running`=0, `cycle_count`=0, state=HALT, debounced button state=1 (released), debounce counters=0, `div_clk` history=0.
- **Button path, per button:**
  - 2-flop synchronizer.
  - Debounce counter: increments while the synced value differs from the accepted value; clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the accepted value takes the synced value and the counter clears.
  - A press is a one-cycle registered pulse on an accepted 1→0 transition. Release produces no event.
- **Edge detect:** `div_clk` is registered once. `edge` = `div_clk` & ~`div_clk_q`.
- **State machine**, evaluated every `clk_in` cycle:
  - HALT:
    - run press and `halt_req`=0 → RUN.
    - Otherwise, step press → STEP. This applies regardless of `halt_req`.
    - Run press together with step press → RUN wins, but only if `halt_req`=0.
  - RUN:
    - `halt_req`=1 → HALT.
    - Else run press → HALT.
    - Else on `edge`, issue `cpu_en`.
    - Step press is ignored.
  - STEP: on `edge`, issue one `cpu_en` and return to HALT. Presses are ignored while waiting.
- **Priority in RUN:** `halt_req` beats `edge`. If both occur in the same cycle, no pulse is issued.
- **`running`:** registered, equal to (state==RUN).
- **`cycle_count`:** increments by 1 in each cycle where `cpu_en`=1. Wraps from 2^CNT_W-1 to 0.

## Timing
- **`cpu_en` latency:** asserted exactly one `clk_in` cycle after the cycle in which `edge` is true. It is high for exactly one cycle, and at most once per `div_clk` period.
- **`div_clk` held high:** produces a single pulse, never repeated pulses.
- **Button-to-press latency:** 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the pin transition settles. The state changes in the cycle after the press pulse.
- **Bounce:** any glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- **`cycle_count`:** updates in the same cycle `cpu_en` is high, visible the following cycle.
- **Reset mid-operation:** async reset immediately clears all state. A pending STEP is discarded.

## Configuration
- Macro: `CPU_RUN_CTRL_CYCLE_COUNT_EN`.
- **Defined:** the `cycle_count` register and incrementer are built, as described above.
- **Undefined:** no counter logic is built and `cycle_count` is tied to 0. The port stays present.

## Structure
- **Shared package** `cpu_ctrl_pkg`: enum `run_state_t` {HALT, RUN, STEP} and the localparam default for DEBOUNCE_CYCLES.
- **Sub-module** `button_debouncer`: synchronizer, debounce counter, press pulse. Parameterized by DEBOUNCE_CYCLES and instantiated twice.
- Edge detect, state machine and counter stay in `cpu_run_ctrl`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and `div_clk` period 6 `clk_in` cycles.
- **Reset, then idle:** drive `div_clk` for 10 periods → `cpu_en` never high, `running`=0, `cycle_count`=0.
- **Run press:** hold `btn_run_n`=0 for 10 cycles → `running`=1. Then `cpu_en` pulses one cycle after each `div_clk` rise: 5 periods → `cycle_count`=5.
- **Step presses:** two step presses from HALT, each held 10 cycles → exactly 2 `cpu_en` pulses, `cycle_count`=2, `running` stays 0.
- **Bounce:** `btn_step_n` toggled every 2 cycles for 20 cycles, then released → no `cpu_en`, state remains HALT.
- **Halt request in RUN:** in RUN, assert `halt_req` in the same cycle as a `div_clk` rise → no `cpu_en`, `running`=0 next cycle. A run press while `halt_req`=1 stays HALT; a step press still gives 1 pulse.
- **Wrap and macro:** with CNT_W=3 and the macro defined, 9 pulses → `cycle_count`=1. With the macro undefined → `cycle_count`=0 throughout.
